// File: rtl/traffic_phase_ctrl_if.sv
// traffic_phase_ctrl_if: mode inputs and phase/lamp outputs of the intersection controller
interface traffic_phase_ctrl_if #(
    parameter int N_PHASE = 4,
    parameter int CNT_W   = 10
);
    localparam int PW = (N_PHASE > 1) ? $clog2(N_PHASE) : 1;
    logic                   night;
    logic                   hold;
    logic                   ped_req;
    logic                   tick;
    logic [PW-1:0]          phase;
    logic                   is_yellow;
    logic [CNT_W-1:0]       remain;
    logic [3*N_PHASE-1:0]   lamp;
    modport master (output night, hold, ped_req, input tick, phase, is_yellow, remain, lamp);
    modport slave  (input night, hold, ped_req, output tick, phase, is_yellow, remain, lamp);
endinterface

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: round-robin N-phase green/yellow sequencer with night flash, hold and pedestrian shortening
module traffic_phase_ctrl #(
    parameter int N_PHASE   = 4,
    parameter int TICK_DIV  = 50_000_000,
    parameter int GREEN_T   = 30,
    parameter int LEFT_T    = 15,
    parameter int YELLOW_T  = 3,
    parameter int MIN_GREEN = 5,
    parameter int CNT_W     = 10
) (
    input logic                  sys_clk,
    input logic                  sys_rst,
    traffic_phase_ctrl_if.slave  bus
);
    localparam int PW = (N_PHASE > 1) ? $clog2(N_PHASE) : 1;
    localparam int TW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_NIGHT} state_t;

    state_t                 state, state_n;
    logic [TW-1:0]          cnt;
    logic                   tick;
    logic [PW-1:0]          phase, phase_n, phase_nx;
    logic [CNT_W-1:0]       remain, remain_n;
    logic                   flash, flash_n;
    logic [3*N_PHASE-1:0]   lamp;

    assign tick     = (cnt == TW'(TICK_DIV - 1));
    assign phase_nx = (phase == PW'(N_PHASE - 1)) ? '0 : phase + 1'b1;

    // free-running 1 s prescaler, never gated by hold or night
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) cnt <= '0;
        else         cnt <= tick ? '0 : cnt + 1'b1;
    end

    // phase/interval state register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state  <= S_GREEN;
            phase  <= '0;
            remain <= CNT_W'(GREEN_T);
            flash  <= 1'b0;
        end else begin
            state  <= state_n;
            phase  <= phase_n;
            remain <= remain_n;
            flash  <= flash_n;
        end
    end

    // next state: night overrides everything, then pedestrian load, then hold, then tick countdown
    always_comb begin
        state_n  = state;
        phase_n  = phase;
        remain_n = remain;
        flash_n  = flash;
        if (bus.night) begin
            if (state != S_NIGHT) begin
                state_n  = S_NIGHT;
                remain_n = '0;
                flash_n  = 1'b1;
            end else if (tick) begin
                flash_n = ~flash;
            end
        end else if (state == S_NIGHT) begin
            state_n  = S_GREEN;
            phase_n  = '0;
            remain_n = CNT_W'(GREEN_T);
            flash_n  = 1'b0;
        end else if (bus.ped_req && state == S_GREEN && remain > CNT_W'(MIN_GREEN)) begin
            remain_n = CNT_W'(MIN_GREEN);
        end else if (!bus.hold && tick) begin
            if (remain > CNT_W'(1)) begin
                remain_n = remain - 1'b1;
            end else if (state == S_GREEN) begin
                state_n  = S_YELLOW;
                remain_n = CNT_W'(YELLOW_T);
            end else begin
                state_n  = S_GREEN;
                phase_n  = phase_nx;
                remain_n = phase_nx[0] ? CNT_W'(LEFT_T) : CNT_W'(GREEN_T);
            end
        end
    end

    // lamp decode from registered state only: {R,Y,G} per phase
    always_comb begin
        lamp = '0;
        for (int k = 0; k < N_PHASE; k++)
            lamp[3*k +: 3] = (state == S_NIGHT) ? (flash ? 3'b010 : 3'b000) :
                             (PW'(k) == phase)  ? ((state == S_YELLOW) ? 3'b010 : 3'b001) :
                                                  3'b100;
    end

    assign bus.tick      = tick;
    assign bus.phase     = phase;
    assign bus.is_yellow = (state == S_YELLOW);
    assign bus.remain    = remain;
    assign bus.lamp      = lamp;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: scoreboard bench for the phase controller with a reduced timing set
module tb_traffic_phase_ctrl;
    localparam int N  = 4;
    localparam int TD = 4;
    localparam int GT = 6;
    localparam int LT = 4;
    localparam int YT = 2;
    localparam int MG = 2;

    typedef struct {
        logic        t;
        logic [1:0]  ph;
        logic        y;
        logic [9:0]  rem;
        logic [11:0] lamp;
    } exp_t;

    logic clk = 0;
    logic rst = 1;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sb[$];
    int   ph_seen[$];
    int   n_ticks;

    int   m_cnt, m_phase, m_rem;
    bit   m_yel, m_nm, m_flash;

    traffic_phase_ctrl_if #(.N_PHASE(N), .CNT_W(10)) bus ();

    traffic_phase_ctrl #(
        .N_PHASE(N), .TICK_DIV(TD), .GREEN_T(GT), .LEFT_T(LT),
        .YELLOW_T(YT), .MIN_GREEN(MG), .CNT_W(10)
    ) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_cnt = 0; m_phase = 0; m_rem = GT; m_yel = 0; m_nm = 0; m_flash = 0;
        sb.delete();
    endtask

    function automatic logic [11:0] lamp_m();
        logic [11:0] l;
        for (int k = 0; k < N; k++) begin
            if (m_nm)             l[3*k +: 3] = m_flash ? 3'b010 : 3'b000;
            else if (k == m_phase) l[3*k +: 3] = m_yel ? 3'b010 : 3'b001;
            else                  l[3*k +: 3] = 3'b100;
        end
        return l;
    endfunction

    task automatic model_step();
        bit t;
        t = (m_cnt == TD - 1);
        if (bus.night) begin
            if (!m_nm) begin m_nm = 1; m_rem = 0; m_flash = 1; end
            else if (t) m_flash = !m_flash;
        end else if (m_nm) begin
            m_nm = 0; m_phase = 0; m_yel = 0; m_rem = GT; m_flash = 0;
        end else if (bus.ped_req && !m_yel && m_rem > MG) begin
            m_rem = MG;
        end else if (!bus.hold && t) begin
            if (m_rem > 1) m_rem--;
            else if (!m_yel) begin m_yel = 1; m_rem = YT; end
            else begin
                m_phase = (m_phase + 1) % N;
                m_yel = 0;
                m_rem = (m_phase % 2) ? LT : GT;
            end
        end
        m_cnt = (m_cnt + 1) % TD;
    endtask

    task automatic step();
        exp_t e;
        model_step();
        e.t = (m_cnt == TD - 1); e.ph = 2'(m_phase); e.y = m_nm ? 1'b0 : m_yel;
        e.rem = 10'(m_rem); e.lamp = lamp_m();
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("tick", bus.tick, e.t);
        check("phase", bus.phase, e.ph);
        check("is_yellow", bus.is_yellow, e.y);
        check("remain", bus.remain, e.rem);
        check("lamp", bus.lamp, e.lamp);
        if (bus.tick) n_ticks++;
        if (ph_seen.size() == 0 || ph_seen[$] != int'(bus.phase)) ph_seen.push_back(int'(bus.phase));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tick"}, bus.tick, 0);
        check({tag, "_phase"}, bus.phase, 0);
        check({tag, "_yel"}, bus.is_yellow, 0);
        check({tag, "_remain"}, bus.remain, GT);
        check({tag, "_lamp"}, bus.lamp, 12'h921);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        int i;
        bus.night = 0; bus.hold = 0; bus.ped_req = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst = 0;
        model_reset();

        n_ticks = 0;
        ph_seen.delete();
        repeat (4 * 28 * TD) step();
        check("tick_count", n_ticks, 4 * 28);
        check("seq_len_ok", ph_seen.size() >= 5, 1);
        for (int k = 0; k < 5 && k < ph_seen.size(); k++) check("phase_seq", ph_seen[k], exp_seq[k]);
        check("wrap_phase", bus.phase, 0);
        check("wrap_remain", bus.remain, GT);

        i = 0;
        while (i < 200 && !(m_phase == 0 && !m_yel && m_rem == 5)) begin step(); i++; end
        check("ped_setup", bus.remain, 5);
        bus.ped_req = 1; step(); bus.ped_req = 0;
        check("ped_load", bus.remain, MG);
        bus.ped_req = 1; step(); bus.ped_req = 0;
        check("ped_at_min", bus.remain <= MG, 1);
        i = 0;
        while (i < 200 && !m_yel) begin step(); i++; end
        bus.ped_req = 1; step(); bus.ped_req = 0;
        check("ped_yellow", bus.is_yellow, 1);

        i = 0;
        while (i < 200 && !(m_phase == 1 && !m_yel && m_rem == LT && m_cnt == TD - 1)) begin step(); i++; end
        bus.ped_req = 1; step(); bus.ped_req = 0;
        check("ped_on_tick", bus.remain, MG);

        i = 0;
        while (i < 200 && !(m_phase == 2 && !m_yel && m_rem == 4)) begin step(); i++; end
        bus.hold = 1;
        repeat (12) step();
        check("hold_remain", bus.remain, 4);
        check("hold_phase", bus.phase, 2);
        bus.ped_req = 1; step(); bus.ped_req = 0;
        check("ped_in_hold", bus.remain, MG);
        bus.hold = 0;
        repeat (2 * TD) step();

        i = 0;
        while (i < 200 && !(m_phase == 2 && !m_yel && m_rem == 3)) begin step(); i++; end
        bus.night = 1;
        step();
        check("night_remain", bus.remain, 0);
        repeat (3 * TD) step();
        bus.ped_req = 1; step(); bus.ped_req = 0;
        repeat (TD) step();
        bus.night = 0;
        step();
        check("night_exit_phase", bus.phase, 0);
        check("night_exit_remain", bus.remain, GT);
        repeat (5) step();
        bus.night = 1; bus.hold = 1;
        repeat (3 * TD + 1) step();
        bus.night = 0; bus.hold = 0;
        repeat (3 * TD) step();

        i = 0;
        while (i < 300 && !m_yel) begin step(); i++; end
        check("pre_rst_yel", bus.is_yellow, 1);
        #3 rst = 1;
        #1 check_reset_vals("async_rst");
        model_reset();
        @(posedge clk);
        #1 check_reset_vals("rst_held");
        rst = 0;
        ph_seen.delete();
        repeat (40) step();
        check("restart_first_phase", ph_seen[0], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
